// File: rtl/weighted_rr_pkg.sv
// weighted_rr_pkg: shared defaults and port-index type for the weighted round-robin arbiter
package weighted_rr_pkg;
  localparam int NUM_PORTS_DEF = 4;
  localparam int WEIGHT_W_DEF = 4;
  localparam int PORT_IDX_W = $clog2(NUM_PORTS_DEF);
  typedef logic [PORT_IDX_W-1:0] port_idx_t;
endpackage

// File: rtl/rr_prio_pick.sv
// rr_prio_pick: combinational rotating-priority pick, searching upward from start_i with wrap
module rr_prio_pick #(
  parameter int NUM_PORTS = 4,
  localparam int IDX_W = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     start_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 valid_o
);
  logic [IDX_W-1:0] pos [NUM_PORTS];
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_pos
    assign pos[i] = IDX_W'((int'(start_i) + i) % NUM_PORTS);
  end
  // Walk from the farthest candidate back to start_i so the nearest requester wins.
  always_comb begin
    idx_o = '0;
    valid_o = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      if (req_i[pos[i]]) begin
        idx_o = pos[i];
        valid_o = 1'b1;
      end
    gnt_o = valid_o ? (NUM_PORTS'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/weighted_rr_arbiter.sv
// weighted_rr_arbiter: round-robin arbiter with per-port burst weights and owner lock,
// registered one-hot grant.
module weighted_rr_arbiter
  import weighted_rr_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int WEIGHT_W = WEIGHT_W_DEF,
  localparam int IDX_W = $clog2(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          req_i,
  input  logic [NUM_PORTS*WEIGHT_W-1:0] weight_i,
  input  logic                          lock_i,
  output logic [NUM_PORTS-1:0]          gnt_o,
  output logic [IDX_W-1:0]              gnt_id_o,
  output logic                          gnt_valid_o
);
  logic [IDX_W-1:0] owner_q, owner_d, start, pick_idx;
  logic [WEIGHT_W-1:0] cnt_q, cnt_d, wgt_q, wgt_d, pick_w;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d, pick_gnt;
  logic valid_q, valid_d, pick_valid, hold;
  // The owner is searched last, so a lone exhausted owner is simply re-granted as a new burst.
  assign start = (owner_q == IDX_W'(NUM_PORTS - 1)) ? '0 : owner_q + 1'b1;
  assign hold = valid_q && req_i[owner_q] && (lock_i || cnt_q < wgt_q);
  rr_prio_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .req_i   (req_i),
    .start_i (start),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );
  always_comb begin
    pick_w = weight_i[int'(pick_idx) * WEIGHT_W +: WEIGHT_W];
    owner_d = (!hold && pick_valid) ? pick_idx : owner_q;
    valid_d = hold || pick_valid;
    gnt_d = hold ? gnt_q : pick_gnt;
    cnt_d = hold ? ((&cnt_q) ? cnt_q : cnt_q + 1'b1) : (pick_valid ? WEIGHT_W'(1) : '0);
    wgt_d = hold ? wgt_q : (pick_valid ? ((pick_w == '0) ? WEIGHT_W'(1) : pick_w) : '0);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      owner_q <= IDX_W'(NUM_PORTS - 1);
      cnt_q <= '0;
      wgt_q <= '0;
      gnt_q <= '0;
      valid_q <= 1'b0;
    end else begin
      owner_q <= owner_d;
      cnt_q <= cnt_d;
      wgt_q <= wgt_d;
      gnt_q <= gnt_d;
      valid_q <= valid_d;
    end
  end
  assign gnt_o = gnt_q;
  assign gnt_valid_o = valid_q;
  assign gnt_id_o = valid_q ? owner_q : '0;
endmodule

// File: doc/weighted_rr_arbiter.md
WEIGHTED_RR_ARBITER -- requirements
Module: weighted_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of requesters (legal 2..32).
REQ-002 SHALL have parameter WEIGHT_W, default 4, width of each per-port weight field.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_i  input  NUM_PORTS  per-port request, bit 0 = port 0.
REQ-006 SHALL have port weight_i  input  NUM_PORTS*WEIGHT_W  per-port burst weight, port p at bits [p*WEIGHT_W +: WEIGHT_W].
REQ-007 SHALL have port lock_i  input  1  current owner requests the grant be held beyond its weight.
REQ-008 SHALL have port gnt_o  output  NUM_PORTS  registered one-hot grant.
REQ-009 SHALL have port gnt_id_o  output  $clog2(NUM_PORTS)  binary index of the granted port.
REQ-010 SHALL have port gnt_valid_o  output  1  high when gnt_o is non-zero.

Function
REQ-011 SHALL register all outputs: the grant decided from inputs in cycle t appears in cycle t+1.
REQ-012 SHALL keep gnt_o one-hot or zero at all times; gnt_valid_o equals OR of gnt_o; gnt_id_o matches gnt_o, 0 when idle.
REQ-013 SHALL keep state: owner pointer (last granted port), burst counter (WEIGHT_W bits), valid flag.
REQ-014 SHALL treat weight 0 as weight 1 (effective weight = max(weight,1)).
REQ-015 SHALL latch the owner's effective weight at burst start; weight_i changes mid-burst take effect at the next burst.
REQ-016 SHALL hold the grant on the owner next cycle when req_i[owner]=1 and (lock_i=1 or burst counter < latched weight); burst counter increments, saturating at all-ones.
REQ-017 SHALL otherwise re-arbitrate round-robin: search starts at owner+1, wraps modulo NUM_PORTS, owner itself searched last; winner starts a new burst with counter = 1.
REQ-018 SHALL, when only the owner requests and its weight is exhausted, re-grant the owner as a new burst (counter = 1, weight re-latched) with no idle cycle.
REQ-019 SHALL, when owner drops its request, grant the next requester in the following cycle (no dead cycle if any request is pending).
REQ-020 SHALL, when req_i = 0, drive gnt_o = 0, gnt_valid_o = 0 next cycle, keeping owner pointer unchanged.
REQ-021 SHALL ignore lock_i when no grant is valid or owner's request is low.

Reset
REQ-022 SHALL, on reset low at a clk edge, set gnt_o = 0, gnt_id_o = 0, gnt_valid_o = 0, burst counter = 0, latched weight = 0, owner pointer = NUM_PORTS-1 (port 0 highest priority first).
REQ-023 SHALL abandon any burst or lock in progress on reset; no state survives.

Structure
REQ-024 SHALL place default NUM_PORTS/WEIGHT_W constants and a port-index typedef in shared package weighted_rr_pkg.
REQ-025 SHALL implement the rotating search in sub-module rr_prio_pick (NUM_PORTS-parametrised: req vector + start pointer -> one-hot winner + index + any-valid), combinational.

Verification
REQ-026 SHALL cover: N=4, all weights 1, req_i=1111 held -> gnt_o 0001,0010,0100,1000,0001 on consecutive cycles.
REQ-027 SHALL cover: weights {p3=3, others 1}, req_i=1001 held -> gnt_o 0001 x1, 1000 x3, 0001 x1, repeating.
REQ-028 SHALL cover: weight p0=4, req_i=0011, drop req_i[0] after 2 grant cycles -> gnt_o=0010 the next cycle.
REQ-029 SHALL cover: all weights 1, req_i=1111, lock_i high for 5 cycles while port 1 owns -> port 1 held 6 cycles total, then 0100.
REQ-030 SHALL cover: req_i=0 -> gnt_valid_o=0, gnt_o=0; weight 0 on a port -> 1-cycle bursts; req_i=0100 sole requester weight 2 -> continuous 0100.
REQ-031 SHALL cover: reset low mid-burst of port 2 -> outputs zero next cycle; then req_i=0101 -> gnt_o=0001 first.
